note_tone_gen: RTL
==================

Name: note_tone_gen

Overview:
Multi-channel programmable square-wave tone generator. It replaces fixed per-note dividers with one table-driven divider per channel. Each channel is loaded over a valid/ready command port with a chromatic note, octave and rest. Period changes take effect only at half-period boundaries, so TONE never glitches. Outputs drive the speaker/PWM stage of the piano design.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz; used at elaboration to build the half-period table.
CH_W, 1, channel-select width; NUM_CH = 2**CH_W.
CNT_W, 18, half-period counter width; elaboration fails if the C4 half-period count exceeds 2**CNT_W.
OCT_W, 2, octave-shift field width.

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous, active-low reset
NOTE_VALID  in  1  command valid
NOTE_READY  out  1  command ready (combinational) = ~pending[NOTE_CH]
NOTE_CH  in  CH_W  target channel
NOTE_IDX  in  4  0..11 = C,C#,D,D#,E,F,F#,G,G#,A,A#,B; 12..15 = rest
OCTAVE  in  OCT_W  octave shift above octave 4 (frequency x 2**OCTAVE)
TONE  out  NUM_CH  per-channel square wave
ACTIVE  out  NUM_CH  per-channel sounding flag

Behaviour:
- Interface: one clock, CLK. Reset RESET_N is asynchronous and active-low.
- Reset: every counter, TONE, ACTIVE and pending flag goes to 0. NOTE_READY is therefore 1 for all channels.
- Table: HP[n] = floor((CLK_HZ*100 + Fc[n]) / (2*Fc[n])), with Fc in centi-Hz: 26163,27718,29366,31113,32963,34923,36999,39200,41530,44000,46616,49388. At 100 MHz this gives C = 191110 and A = 113636.
- Terminal count: T = (HP[idx] >> OCTAVE) - 1.
- Handshake: a command is accepted when NOTE_VALID and NOTE_READY are both 1 on a rising CLK edge.
- Per-channel state, ACTIVE=0 (IDLE):
  - A note command loads T. On the next cycle ACTIVE=1, counter=0, TONE=0.
  - A rest command is accepted and does nothing; no pending flag is set.
- Per-channel state, ACTIVE=1 (RUN):
  - The counter increments each cycle.
  - When counter==T: counter<=0 and TONE toggles (the boundary).
  - An accepted command sets pending and stores idx/octave. NOTE_READY is then 0 for that channel.
- Boundary with pending set:
  - Note: TONE toggles, counter<=0, T<=new T, pending<=0.
  - Rest: TONE<=0, counter<=0, ACTIVE<=0, pending<=0.
- A command accepted in the same cycle as a boundary is applied at the following boundary, not the current one.
- Period is exactly 2*(T+1) cycles. After IDLE->RUN, the first TONE rise occurs T+1 cycles after ACTIVE rises.
- Channels are fully independent. Only one command can be accepted per cycle.
- RESET_N asserted mid-note: all outputs drop to 0 immediately. Any pending command is discarded.

Optional Feature:
TONE_GEN_MIX_EN:
- When defined, adds output MIX [CH_W:0], a registered count of channels with TONE=1. It has 1-cycle latency and resets to 0.
- When undefined, the port and its logic are absent.

Test Plan:
- Reset, then ch0 A, octave 0 (T=113635) -> ACTIVE[0]=1 next cycle; TONE[0] rises 113636 cycles later; period 227272 cycles.
- While ch0 runs A, send C octave 0 -> NOTE_READY(ch0)=0 until the next boundary. The next half-period uses T=191109. No TONE pulse is shorter than 113636 cycles.
- ch1 A, octave 1 (T=56817) together with ch0 C4 (T=191109) -> independent periods of 113636 and 382220 cycles; ch0 pending does not block ch1 commands.
- Rest (NOTE_IDX=12) to running ch0 -> TONE[0]=0 and ACTIVE[0]=0 at the next boundary. Rest to idle ch0 -> no change, READY stays 1.
- Command accepted on the exact boundary cycle -> current half-period keeps the old T; new T applies one half-period later.
- Pull RESET_N low mid-half-period with a pending command -> TONE, ACTIVE and MIX go to 0 asynchronously. After release the channel is idle and READY=1.

Source files
------------

// File: rtl/note_tone_gen_if.sv
// Command port of note_tone_gen: valid/ready handshake carrying
// channel, chromatic note index and octave shift.
interface note_tone_gen_if #(
    parameter int CH_W  = 1,
    parameter int OCT_W = 2
) ();
    logic             NOTE_VALID;
    logic             NOTE_READY;
    logic [CH_W-1:0]  NOTE_CH;
    logic [3:0]       NOTE_IDX;
    logic [OCT_W-1:0] OCTAVE;

    modport master (
        output NOTE_VALID,
        output NOTE_CH,
        output NOTE_IDX,
        output OCTAVE,
        input  NOTE_READY
    );

    modport slave (
        input  NOTE_VALID,
        input  NOTE_CH,
        input  NOTE_IDX,
        input  OCTAVE,
        output NOTE_READY
    );
endinterface

// File: rtl/note_tone_gen.sv
// Multi-channel table-driven square-wave tone generator.
// Optional macro TONE_GEN_MIX_EN adds the registered MIX count output.
module note_tone_gen #(
    parameter int CLK_HZ = 100000000,
    parameter int CH_W   = 1,
    parameter int CNT_W  = 18,
    parameter int OCT_W  = 2
) (
    input  logic                CLK,
    input  logic                RESET_N,
    note_tone_gen_if.slave      cmd,
    output logic [2**CH_W-1:0]  TONE,
    output logic [2**CH_W-1:0]  ACTIVE
`ifdef TONE_GEN_MIX_EN
    ,
    output logic [CH_W:0]       MIX
`endif
);

    localparam int NUM_CH = 2**CH_W;

    typedef logic [11:0][CNT_W-1:0] hp_tab_t;

    function automatic logic [63:0] fc_of(input int n);
        case (n)
            0:       return 64'd26163;
            1:       return 64'd27718;
            2:       return 64'd29366;
            3:       return 64'd31113;
            4:       return 64'd32963;
            5:       return 64'd34923;
            6:       return 64'd36999;
            7:       return 64'd39200;
            8:       return 64'd41530;
            9:       return 64'd44000;
            10:      return 64'd46616;
            default: return 64'd49388;
        endcase
    endfunction

    function automatic logic [63:0] hp_full(input int n);
        return (64'(CLK_HZ) * 64'd100 + fc_of(n)) / (64'd2 * fc_of(n));
    endfunction

    function automatic hp_tab_t build_tab();
        hp_tab_t t;
        for (int n = 0; n < 12; n++) begin
            t[n] = CNT_W'(hp_full(n));
        end
        return t;
    endfunction

    localparam hp_tab_t HP = build_tab();

    // C is the longest half-period, so it bounds the counter width.
    if (hp_full(0) > (64'd1 << CNT_W)) begin : g_cnt_w_chk
        $fatal(1, "note_tone_gen: C4 half-period exceeds 2**CNT_W");
    end

    function automatic logic [CNT_W-1:0] term_of(
        input logic [3:0]       idx,
        input logic [OCT_W-1:0] oct
    );
        logic [CNT_W-1:0] hp;
        hp = '0;
        for (int n = 0; n < 12; n++) begin
            if (idx == 4'(n)) hp = HP[n];
        end
        return (hp >> oct) - CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] cnt_q  [NUM_CH];
    logic [CNT_W-1:0] cnt_d  [NUM_CH];
    logic [CNT_W-1:0] term_q [NUM_CH];
    logic [CNT_W-1:0] term_d [NUM_CH];
    logic [3:0]       pidx_q [NUM_CH];
    logic [3:0]       pidx_d [NUM_CH];
    logic [OCT_W-1:0] poct_q [NUM_CH];
    logic [OCT_W-1:0] poct_d [NUM_CH];
    logic [NUM_CH-1:0] tone_q, tone_d;
    logic [NUM_CH-1:0] act_q, act_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] hit, bnd;
    logic              accept;
    logic              cmd_note;

    assign cmd.NOTE_READY = ~pend_q[cmd.NOTE_CH];
    assign accept         = cmd.NOTE_VALID & cmd.NOTE_READY;
    assign cmd_note       = cmd.NOTE_IDX < 4'd12;

    always_comb begin
        hit = '0;
        bnd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = accept && (cmd.NOTE_CH == CH_W'(i));
            bnd[i] = act_q[i] && (cnt_q[i] == term_q[i]);
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        term_d = term_q;
        pidx_d = pidx_q;
        poct_d = poct_q;
        tone_d = tone_q;
        act_d  = act_q;
        pend_d = pend_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!act_q[i]) begin
                // Rests to an idle channel are consumed without effect.
                if (hit[i] && cmd_note) begin
                    act_d[i]  = 1'b1;
                    tone_d[i] = 1'b0;
                    cnt_d[i]  = '0;
                    term_d[i] = term_of(cmd.NOTE_IDX, cmd.OCTAVE);
                end
            end else begin
                if (bnd[i]) begin
                    cnt_d[i] = '0;
                    if (pend_q[i]) begin
                        pend_d[i] = 1'b0;
                        if (pidx_q[i] < 4'd12) begin
                            tone_d[i] = ~tone_q[i];
                            term_d[i] = term_of(pidx_q[i], poct_q[i]);
                        end else begin
                            tone_d[i] = 1'b0;
                            act_d[i]  = 1'b0;
                        end
                    end else begin
                        tone_d[i] = ~tone_q[i];
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                // Held until the next boundary, never the current one.
                if (hit[i]) begin
                    pend_d[i] = 1'b1;
                    pidx_d[i] = cmd.NOTE_IDX;
                    poct_d[i] = cmd.OCTAVE;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                term_q[i] <= '0;
                pidx_q[i] <= '0;
                poct_q[i] <= '0;
            end
            tone_q <= '0;
            act_q  <= '0;
            pend_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
            pidx_q <= pidx_d;
            poct_q <= poct_d;
            tone_q <= tone_d;
            act_q  <= act_d;
            pend_q <= pend_d;
        end
    end

    assign TONE   = tone_q;
    assign ACTIVE = act_q;

`ifdef TONE_GEN_MIX_EN
    logic [CH_W:0] mix_q, mix_d;

    always_comb begin
        mix_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_d = mix_d + (CH_W+1)'(tone_q[i]);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) mix_q <= '0;
        else          mix_q <= mix_d;
    end

    assign MIX = mix_q;
`endif

endmodule
